// File: rtl/fetch_pc_gen_pkg.sv
// Shared types for the IF-stage PC generator: fetch packet and reset constants.
package fetch_pc_gen_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0060;
  localparam int          W_BITS_DEF   = 8;

  // Everything the IF/ID register carries for one fetched instruction.
  typedef struct packed {
    logic [31:0]           instr;
    logic [31:0]           pc;
    logic                  bp_br_en;
    logic [W_BITS_DEF-1:0] y_out;
    logic [31:0]           bp_target;
  } fetch_pkt_t;

  // Where fetch resumes after a mispredict: the resolved target, or the fall-through.
  function automatic logic [31:0] recovery_target(input logic        br_en,
                                                  input logic [31:0] br_pc,
                                                  input logic [31:0] alu_out);
    return br_en ? alu_out : br_pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// I-cache read bus: a request held until a one-cycle response pulse.
interface fetch_pc_gen_if;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp;
  logic [31:0] imem_rdata;

  modport master (output imem_read, output imem_address,
                  input  imem_resp, input  imem_rdata);
  modport slave  (input  imem_read, input  imem_address,
                  output imem_resp, output imem_rdata);
endinterface

// File: rtl/fetch_pc_gen_skid.sv
// Single-entry buffer that parks a fetched packet while IF/ID is stalled.
module fetch_skid
  import fetch_pc_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       clear_i,
  input  fetch_pkt_t pkt_i,
  output logic       valid_o,
  output fetch_pkt_t pkt_o
);
  logic       valid_q;
  fetch_pkt_t pkt_q;

  // Clear wins over load so a flush in the same cycle leaves the buffer empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pkt_q   <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pkt_q   <= pkt_i;
    end
  end

  assign valid_o = valid_q;
  assign pkt_o   = pkt_q;
endmodule

// File: rtl/fetch_pc_gen.sv
// IF-stage PC generator: sequences I-cache reads, captures predictor output per
// packet, and redirects fetch on a mispredict flush.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          W_BITS   = W_BITS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              bp_rst,
  input  logic              exmem_br_en,
  input  logic [31:0]       exmem_pc,
  input  logic [31:0]       exmem_alu_out,
  output logic [31:0]       if_pc,
  input  logic              if_bp_br_en,
  input  logic [W_BITS-1:0] if_y_out,
  input  logic [31:0]       if_bp_target,
  fetch_pc_gen_if.master    imem,
  output logic              ifid_valid,
  output logic [31:0]       ifid_instr,
  output logic [31:0]       ifid_pc,
  output logic              ifid_bp_br_en,
  output logic [W_BITS-1:0] ifid_y_out,
  output logic [31:0]       ifid_bp_target
);
  // SQUASH: a stale request is in flight and must be drained before refetching.
  typedef enum logic [1:0] {FETCH, HOLD, SQUASH} fetch_state_t;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_d;
  logic         ifid_valid_q, ifid_valid_d;
  fetch_pkt_t   ifid_q, ifid_d;
  fetch_pkt_t   new_pkt, skid_pkt;
  logic         skid_ld, skid_clr, skid_valid;
  logic [31:0]  rt;
  logic         resp;

  assign resp = imem.imem_resp;
  assign rt   = recovery_target(exmem_br_en, exmem_pc, exmem_alu_out);

  assign new_pkt = '{instr:     imem.imem_rdata,
                     pc:        pc_q,
                     bp_br_en:  if_bp_br_en,
                     y_out:     if_y_out,
                     bp_target: if_bp_target};

  fetch_skid u_skid (
    .clk     (clk),
    .rst_n   (rst),
    .load_i  (skid_ld),
    .clear_i (skid_clr),
    .pkt_i   (new_pkt),
    .valid_o (skid_valid),
    .pkt_o   (skid_pkt)
  );

  // State and datapath registers; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_q       <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_q       <= ifid_d;
    end
  end

  // Next state: a flush drains a pending request via SQUASH, otherwise stalls park in HOLD.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (bp_rst)             state_d = resp ? FETCH : SQUASH;
               else if (resp && stall) state_d = HOLD;
      HOLD:    if (bp_rst || !stall)   state_d = FETCH;
      SQUASH:  if (resp)               state_d = FETCH;
      default:                         state_d = FETCH;
    endcase
  end

  // PC, request address, IF/ID and skid control; bp_rst overrides stall.
  always_comb begin
    pc_d         = pc_q;
    req_d        = req_addr_q;
    ifid_valid_d = ifid_valid_q;
    ifid_d       = ifid_q;
    skid_ld      = 1'b0;
    skid_clr     = 1'b0;
    if (bp_rst) begin
      pc_d         = rt;
      ifid_valid_d = 1'b0;
      skid_clr     = 1'b0 | 1'b1;
      // The bus is free to retarget only when nothing is outstanding after this edge.
      if (state_q == HOLD || resp) req_d = rt;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (resp) begin
            pc_d  = if_bp_target;
            req_d = if_bp_target;
            if (stall) begin
              skid_ld = 1'b1;
            end else begin
              ifid_d       = new_pkt;
              ifid_valid_d = 1'b1;
            end
          end else if (!stall) begin
            ifid_valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_d       = skid_pkt;
            ifid_valid_d = skid_valid;
            skid_clr     = 1'b1;
          end
        end
        SQUASH: begin
          if (!stall) ifid_valid_d = 1'b0;
          if (resp)   req_d        = pc_q;
        end
        default: ;
      endcase
    end
  end

  // Bus outputs: a request is held in every state except HOLD.
  always_comb begin
    imem.imem_read    = (state_q != HOLD);
    imem.imem_address = req_addr_q;
  end

  assign if_pc          = pc_q;
  assign ifid_valid     = ifid_valid_q;
  assign ifid_instr     = ifid_q.instr;
  assign ifid_pc        = ifid_q.pc;
  assign ifid_bp_br_en  = ifid_q.bp_br_en;
  assign ifid_y_out     = ifid_q.y_out;
  assign ifid_bp_target = ifid_q.bp_target;
endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen with a packet scoreboard on the IF/ID output.
module tb_fetch_pc_gen;
  import fetch_pc_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, bp_rst, exmem_br_en;
  logic [31:0] exmem_pc, exmem_alu_out;
  logic [31:0] if_pc, if_bp_target;
  logic        if_bp_br_en;
  logic [7:0]  if_y_out;
  logic        ifid_valid, ifid_bp_br_en;
  logic [31:0] ifid_instr, ifid_pc, ifid_bp_target;
  logic [7:0]  ifid_y_out;

  fetch_pc_gen_if imem_bus ();

  fetch_pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .bp_rst(bp_rst),
    .exmem_br_en(exmem_br_en), .exmem_pc(exmem_pc), .exmem_alu_out(exmem_alu_out),
    .if_pc(if_pc), .if_bp_br_en(if_bp_br_en), .if_y_out(if_y_out), .if_bp_target(if_bp_target),
    .imem(imem_bus),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_bp_br_en(ifid_bp_br_en), .ifid_y_out(ifid_y_out), .ifid_bp_target(ifid_bp_target)
  );

  always #5 clk = ~clk;

  // Predictor stub: only 0x68 is predicted taken (to 0x100).
  always_comb begin
    if_bp_br_en  = (if_pc == 32'h68);
    if_bp_target = if_bp_br_en ? 32'h100 : if_pc + 32'd4;
    if_y_out     = if_pc[7:0] ^ 8'h5A;
  end

  int checks = 0;
  int failures = 0;
  fetch_pkt_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic br,
                      input logic [7:0] y, input logic [31:0] tgt);
    exp_q.push_back('{instr: instr, pc: pc, bp_br_en: br, y_out: y, bp_target: tgt});
  endtask

  // One-cycle I-cache response pulse.
  task automatic resp(input logic [31:0] data);
    imem_bus.imem_resp  = 1'b1;
    imem_bus.imem_rdata = data;
    step;
    imem_bus.imem_resp  = 1'b0;
    imem_bus.imem_rdata = '0;
  endtask

  // Monitor: a packet is presented when IF/ID advanced at the last edge and holds a live entry.
  initial begin
    logic adv;
    fetch_pkt_t e, a;
    forever begin
      @(posedge clk);
      adv = !stall;
      @(negedge clk);
      if (adv && ifid_valid === 1'b1) begin
        checks++;
        a = '{instr: ifid_instr, pc: ifid_pc, bp_br_en: ifid_bp_br_en,
              y_out: ifid_y_out, bp_target: ifid_bp_target};
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL ifid_pkt: unexpected packet pc=%h instr=%h", ifid_pc, ifid_instr);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            failures++;
            $display("FAIL ifid_pkt: got instr=%h pc=%h br=%b y=%h tgt=%h expected instr=%h pc=%h br=%b y=%h tgt=%h",
                     a.instr, a.pc, a.bp_br_en, a.y_out, a.bp_target,
                     e.instr, e.pc, e.bp_br_en, e.y_out, e.bp_target);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b0; stall = 1'b0; bp_rst = 1'b0;
    exmem_br_en = 1'b0; exmem_pc = '0; exmem_alu_out = '0;
    imem_bus.imem_resp = 1'b0; imem_bus.imem_rdata = '0;
    repeat (2) step;
    chk("rst_addr", imem_bus.imem_address, 32'h60);
    chk("rst_ifid_valid", {31'b0, ifid_valid}, 32'h0);
    chk("rst_ifid_pc", ifid_pc, 32'h0);
    chk("rst_if_pc", if_pc, 32'h60);

    // 1: first fetch, not taken
    rst = 1'b1;
    chk("t1_read", {31'b0, imem_bus.imem_read}, 32'h1);
    step; step;
    chk("t1_addr", imem_bus.imem_address, 32'h60);
    push(32'h13, 32'h60, 1'b0, 8'h3A, 32'h64);
    resp(32'h13);
    chk("t1_next_addr", imem_bus.imem_address, 32'h64);
    chk("t1_ifid_valid", {31'b0, ifid_valid}, 32'h1);

    // 3: stalled response at 0x64 parks in the skid
    step;
    stall = 1'b1;
    push(32'hA1, 32'h64, 1'b0, 8'h3E, 32'h68);
    resp(32'hA1);
    chk("t3_hold_read", {31'b0, imem_bus.imem_read}, 32'h0);
    step;
    chk("t3_hold_read2", {31'b0, imem_bus.imem_read}, 32'h0);
    stall = 1'b0;
    step;
    chk("t3_ifid_pc", ifid_pc, 32'h64);
    chk("t3_next_addr", imem_bus.imem_address, 32'h68);
    chk("t3_read", {31'b0, imem_bus.imem_read}, 32'h1);

    // 2: predicted taken at 0x68
    push(32'hB2, 32'h68, 1'b1, 8'h32, 32'h100);
    resp(32'hB2);
    chk("t2_ifid_tgt", ifid_bp_target, 32'h100);
    chk("t2_next_addr", imem_bus.imem_address, 32'h100);

    // 4: flush while 0x100 is outstanding
    step;
    bp_rst = 1'b1; exmem_br_en = 1'b0; exmem_pc = 32'h80;
    step;
    bp_rst = 1'b0;
    chk("t4_sq_addr", imem_bus.imem_address, 32'h100);
    chk("t4_sq_read", {31'b0, imem_bus.imem_read}, 32'h1);
    chk("t4_if_pc", if_pc, 32'h84);
    chk("t4_ifid_valid", {31'b0, ifid_valid}, 32'h0);
    step;
    chk("t4_sq_addr2", imem_bus.imem_address, 32'h100);
    resp(32'hDEAD);
    chk("t4_new_addr", imem_bus.imem_address, 32'h84);
    chk("t4_ifid_valid2", {31'b0, ifid_valid}, 32'h0);
    push(32'hC3, 32'h84, 1'b0, 8'hDE, 32'h88);
    resp(32'hC3);
    chk("t4_next_addr", imem_bus.imem_address, 32'h88);

    // 5: flush and response in the same cycle
    bp_rst = 1'b1; exmem_br_en = 1'b1; exmem_alu_out = 32'h200;
    resp(32'hBEEF);
    bp_rst = 1'b0; exmem_br_en = 1'b0;
    chk("t5_addr", imem_bus.imem_address, 32'h200);
    chk("t5_ifid_valid", {31'b0, ifid_valid}, 32'h0);
    push(32'hD4, 32'h200, 1'b0, 8'h5A, 32'h204);
    resp(32'hD4);
    chk("t5_next_addr", imem_bus.imem_address, 32'h204);

    // 6: reset while 0x204 is outstanding; late response ignored
    step;
    rst = 1'b0;
    #1;
    chk("t6_addr", imem_bus.imem_address, 32'h60);
    chk("t6_if_pc", if_pc, 32'h60);
    chk("t6_ifid_valid", {31'b0, ifid_valid}, 32'h0);
    resp(32'h5555);
    chk("t6_addr_late", imem_bus.imem_address, 32'h60);
    rst = 1'b1;
    step;
    push(32'hE5, 32'h60, 1'b0, 8'h3A, 32'h64);
    resp(32'hE5);
    chk("t6_next_addr", imem_bus.imem_address, 32'h64);

    // Flush while in HOLD with stall still high
    step;
    stall = 1'b1;
    resp(32'hF6);
    chk("hold_read", {31'b0, imem_bus.imem_read}, 32'h0);
    bp_rst = 1'b1; exmem_pc = 32'h300;
    step;
    bp_rst = 1'b0;
    chk("hold_flush_addr", imem_bus.imem_address, 32'h304);
    chk("hold_flush_read", {31'b0, imem_bus.imem_read}, 32'h1);
    chk("hold_flush_valid", {31'b0, ifid_valid}, 32'h0);
    stall = 1'b0;
    step;
    chk("hold_flush_valid2", {31'b0, ifid_valid}, 32'h0);

    step; step;
    chk("sb_empty", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
